// File: rtl/fifo_id_queue.sv
// Synchronous FIFO used as the ID-reflection store of the AXI4 to AXI4-Lite converter.
// Supports optional fall-through and a stateless pass-through mode when DEPTH is 0.
module fifo_id_queue #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  if (DATA_WIDTH == 0) begin : g_width_check
    $fatal(1, "fifo_id_queue: DATA_WIDTH must be greater than 0");
  end

  if (DEPTH == 0) begin : g_pass
    logic unused_inputs;
    assign unused_inputs = ^{clk_i, rst_i, flush_i, testmode_i};

    assign data_o  = data_i;
    assign empty_o = ~push_i;
    assign full_o  = ~pop_i;
    assign usage_o = '0;
  end else begin : g_queue
    localparam logic [ADDR_DEPTH-1:0] LAST_PTR = ADDR_DEPTH'(DEPTH - 1);
    localparam logic [ADDR_DEPTH:0]   FULL_CNT = (ADDR_DEPTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_DEPTH-1:0] rp;
    logic [ADDR_DEPTH-1:0] wp;
    logic [ADDR_DEPTH:0]   cnt;
    logic                  is_empty;
    logic                  bypass;
    logic                  push_eff;
    logic                  pop_eff;
    logic                  unused_testmode;

    assign unused_testmode = testmode_i;

    assign is_empty = (cnt == '0);
    assign full_o   = (cnt == FULL_CNT);
    assign empty_o  = is_empty & ~(FALL_THROUGH & push_i);
    assign usage_o  = cnt[ADDR_DEPTH-1:0];

    // Fall-through push and pop on an empty queue hand the word straight across
    // without touching storage, so both effective strobes are suppressed.
    assign bypass   = FALL_THROUGH & is_empty & push_i & pop_i;
    assign push_eff = push_i & ~full_o & ~bypass;
    assign pop_eff  = pop_i & ~empty_o & ~bypass;

    always_comb begin
      data_o = mem[rp];
      if (FALL_THROUGH && is_empty && push_i) begin
        data_o = data_i;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        rp  <= '0;
        wp  <= '0;
        cnt <= '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
          mem[i] <= '0;
        end
      end else if (flush_i) begin
        rp  <= '0;
        wp  <= '0;
        cnt <= '0;
      end else begin
        if (push_eff) begin
          mem[wp] <= data_i;
          wp      <= (wp == LAST_PTR) ? '0 : wp + 1'b1;
        end
        if (pop_eff) begin
          rp <= (rp == LAST_PTR) ? '0 : rp + 1'b1;
        end
        case ({push_eff, pop_eff})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fifo_id_queue.sv
// Directed bench for fifo_id_queue: DEPTH=4, fall-through DEPTH=4, DEPTH=3 and pass-through instances.
module tb_fifo_id_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  logic tm = 1'b0;

  // DEPTH=4, no fall-through
  logic       rst_a = 1'b0, flush_a = 1'b0, push_a = 1'b0, pop_a = 1'b0;
  logic [7:0] din_a = '0, dout_a;
  logic       full_a, empty_a;
  logic [1:0] usage_a;

  // DEPTH=4, fall-through
  logic       rst_f = 1'b0, flush_f = 1'b0, push_f = 1'b0, pop_f = 1'b0;
  logic [7:0] din_f = '0, dout_f;
  logic       full_f, empty_f;
  logic [1:0] usage_f;

  // DEPTH=3, no fall-through
  logic       rst_c = 1'b0, flush_c = 1'b0, push_c = 1'b0, pop_c = 1'b0;
  logic [7:0] din_c = '0, dout_c;
  logic       full_c, empty_c;
  logic [1:0] usage_c;

  // DEPTH=0 pass-through
  logic       rst_p = 1'b0, flush_p = 1'b0, push_p = 1'b0, pop_p = 1'b0;
  logic [7:0] din_p = '0, dout_p;
  logic       full_p, empty_p;
  logic [0:0] usage_p;

  fifo_id_queue #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(4)) u_a (
    .clk_i(clk), .rst_i(rst_a), .flush_i(flush_a), .testmode_i(tm),
    .full_o(full_a), .empty_o(empty_a), .usage_o(usage_a),
    .data_i(din_a), .push_i(push_a), .data_o(dout_a), .pop_i(pop_a)
  );

  fifo_id_queue #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(4)) u_f (
    .clk_i(clk), .rst_i(rst_f), .flush_i(flush_f), .testmode_i(tm),
    .full_o(full_f), .empty_o(empty_f), .usage_o(usage_f),
    .data_i(din_f), .push_i(push_f), .data_o(dout_f), .pop_i(pop_f)
  );

  fifo_id_queue #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(3)) u_c (
    .clk_i(clk), .rst_i(rst_c), .flush_i(flush_c), .testmode_i(tm),
    .full_o(full_c), .empty_o(empty_c), .usage_o(usage_c),
    .data_i(din_c), .push_i(push_c), .data_o(dout_c), .pop_i(pop_c)
  );

  fifo_id_queue #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(0)) u_p (
    .clk_i(clk), .rst_i(rst_p), .flush_i(flush_p), .testmode_i(tm),
    .full_o(full_p), .empty_o(empty_p), .usage_o(usage_p),
    .data_i(din_p), .push_i(push_p), .data_o(dout_p), .pop_i(pop_p)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_a = 1'b1; rst_f = 1'b1; rst_c = 1'b1;
    tick();
    rst_a = 1'b0; rst_f = 1'b0; rst_c = 1'b0;
    #1;
    vectors++; if (empty_a !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", empty_a); end
    vectors++; if (full_a !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", full_a); end
    vectors++; if (usage_a !== 2'd0) begin miscompares++; $display("FAIL reset_usage: got %0d want 0", usage_a); end
    vectors++; if (dout_a !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", dout_a); end
    vectors++; if (empty_f !== 1'b1) begin miscompares++; $display("FAIL reset_empty_ft: got %b want 1", empty_f); end
    vectors++; if (empty_c !== 1'b1) begin miscompares++; $display("FAIL reset_empty_d3: got %b want 1", empty_c); end
  endtask

  task automatic test_fill;
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    push_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din_a = vals[i];
      tick();
    end
    vectors++; if (full_a !== 1'b1) begin miscompares++; $display("FAIL fill_full: got %b want 1", full_a); end
    vectors++; if (usage_a !== 2'd0) begin miscompares++; $display("FAIL fill_usage_wrap: got %0d want 0", usage_a); end
    vectors++; if (empty_a !== 1'b0) begin miscompares++; $display("FAIL fill_empty: got %b want 0", empty_a); end
    vectors++; if (dout_a !== 8'h11) begin miscompares++; $display("FAIL fill_head: got %h want 11", dout_a); end
    din_a = 8'h55;
    tick();
    push_a = 1'b0;
    #1;
    vectors++; if (full_a !== 1'b1) begin miscompares++; $display("FAIL overflow_full: got %b want 1", full_a); end
    vectors++; if (dout_a !== 8'h11) begin miscompares++; $display("FAIL overflow_head: got %h want 11", dout_a); end
    pop_a = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if (dout_a !== vals[i]) begin miscompares++; $display("FAIL drain_%0d: got %h want %h", i, dout_a, vals[i]); end
      tick();
    end
    pop_a = 1'b0;
    #1;
    vectors++; if (empty_a !== 1'b1) begin miscompares++; $display("FAIL drain_empty: got %b want 1", empty_a); end
    vectors++; if (usage_a !== 2'd0) begin miscompares++; $display("FAIL drain_usage: got %0d want 0", usage_a); end
  endtask

  task automatic test_no_fall_through;
    pop_a = 1'b1; push_a = 1'b0;
    tick();
    pop_a = 1'b0;
    #1;
    vectors++; if (usage_a !== 2'd0) begin miscompares++; $display("FAIL pop_empty_usage: got %0d want 0", usage_a); end
    vectors++; if (empty_a !== 1'b1) begin miscompares++; $display("FAIL pop_empty_flag: got %b want 1", empty_a); end
    din_a = 8'h7E; push_a = 1'b1;
    #1;
    vectors++; if (empty_a !== 1'b1) begin miscompares++; $display("FAIL nft_empty_in_push: got %b want 1", empty_a); end
    tick();
    push_a = 1'b0;
    #1;
    vectors++; if (empty_a !== 1'b0) begin miscompares++; $display("FAIL nft_empty_after: got %b want 0", empty_a); end
    vectors++; if (dout_a !== 8'h7E) begin miscompares++; $display("FAIL nft_data: got %h want 7e", dout_a); end
    vectors++; if (usage_a !== 2'd1) begin miscompares++; $display("FAIL nft_usage: got %0d want 1", usage_a); end
    pop_a = 1'b1;
    tick();
    pop_a = 1'b0;
    #1;
    vectors++; if (empty_a !== 1'b1) begin miscompares++; $display("FAIL nft_pop_empty: got %b want 1", empty_a); end
  endtask

  task automatic test_full_push_pop;
    push_a = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      din_a = 8'(i);
      tick();
    end
    din_a = 8'h99; pop_a = 1'b1;
    #1;
    vectors++; if (full_a !== 1'b1) begin miscompares++; $display("FAIL fpp_full_before: got %b want 1", full_a); end
    tick();
    push_a = 1'b0; pop_a = 1'b0;
    #1;
    vectors++; if (usage_a !== 2'd3) begin miscompares++; $display("FAIL fpp_usage: got %0d want 3", usage_a); end
    vectors++; if (full_a !== 1'b0) begin miscompares++; $display("FAIL fpp_full_after: got %b want 0", full_a); end
    pop_a = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      #1;
      vectors++; if (dout_a !== 8'(i)) begin miscompares++; $display("FAIL fpp_drain_%0d: got %h want %h", i, dout_a, 8'(i)); end
      tick();
    end
    pop_a = 1'b0;
    #1;
    vectors++; if (empty_a !== 1'b1) begin miscompares++; $display("FAIL fpp_not_stored: got %b want 1", empty_a); end
  endtask

  task automatic test_back_to_back;
    din_a = 8'hC0; push_a = 1'b1;
    tick();
    pop_a = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      din_a = 8'hC0 + 8'(i);
      #1;
      vectors++; if (dout_a !== 8'hC0 + 8'(i - 1)) begin miscompares++; $display("FAIL b2b_head_%0d: got %h want %h", i, dout_a, 8'hC0 + 8'(i - 1)); end
      vectors++; if (usage_a !== 2'd1) begin miscompares++; $display("FAIL b2b_usage_%0d: got %0d want 1", i, usage_a); end
      tick();
    end
    push_a = 1'b0;
    #1;
    vectors++; if (dout_a !== 8'hC5) begin miscompares++; $display("FAIL b2b_last: got %h want c5", dout_a); end
    tick();
    pop_a = 1'b0;
    #1;
    vectors++; if (empty_a !== 1'b1) begin miscompares++; $display("FAIL b2b_empty: got %b want 1", empty_a); end
  endtask

  task automatic test_flush_reset;
    push_a = 1'b1;
    din_a = 8'hA1; tick();
    din_a = 8'hA2; tick();
    din_a = 8'hA3; flush_a = 1'b1;
    tick();
    flush_a = 1'b0; push_a = 1'b0;
    #1;
    vectors++; if (empty_a !== 1'b1) begin miscompares++; $display("FAIL flush_empty: got %b want 1", empty_a); end
    vectors++; if (usage_a !== 2'd0) begin miscompares++; $display("FAIL flush_usage: got %0d want 0", usage_a); end
    din_a = 8'hB1; push_a = 1'b1;
    tick();
    push_a = 1'b0;
    #1;
    vectors++; if (dout_a !== 8'hB1) begin miscompares++; $display("FAIL flush_refill: got %h want b1", dout_a); end
    vectors++; if (usage_a !== 2'd1) begin miscompares++; $display("FAIL flush_refill_usage: got %0d want 1", usage_a); end
    din_a = 8'hB2; push_a = 1'b1;
    tick();
    din_a = 8'hB3; rst_a = 1'b1;
    tick();
    rst_a = 1'b0; push_a = 1'b0;
    #1;
    vectors++; if (empty_a !== 1'b1) begin miscompares++; $display("FAIL midrst_empty: got %b want 1", empty_a); end
    vectors++; if (usage_a !== 2'd0) begin miscompares++; $display("FAIL midrst_usage: got %0d want 0", usage_a); end
    vectors++; if (dout_a !== 8'h00) begin miscompares++; $display("FAIL midrst_data: got %h want 00", dout_a); end
  endtask

  task automatic test_fall_through;
    din_f = 8'hA5; push_f = 1'b1; pop_f = 1'b1;
    #1;
    vectors++; if (dout_f !== 8'hA5) begin miscompares++; $display("FAIL ft_bypass_data: got %h want a5", dout_f); end
    vectors++; if (empty_f !== 1'b0) begin miscompares++; $display("FAIL ft_bypass_empty: got %b want 0", empty_f); end
    tick();
    push_f = 1'b0; pop_f = 1'b0;
    #1;
    vectors++; if (empty_f !== 1'b1) begin miscompares++; $display("FAIL ft_after_empty: got %b want 1", empty_f); end
    vectors++; if (usage_f !== 2'd0) begin miscompares++; $display("FAIL ft_after_usage: got %0d want 0", usage_f); end
    din_f = 8'h3C; push_f = 1'b1;
    #1;
    vectors++; if (dout_f !== 8'h3C) begin miscompares++; $display("FAIL ft_push_data: got %h want 3c", dout_f); end
    tick();
    din_f = 8'h4D; pop_f = 1'b1;
    #1;
    vectors++; if (dout_f !== 8'h3C) begin miscompares++; $display("FAIL ft_stored: got %h want 3c", dout_f); end
    vectors++; if (usage_f !== 2'd1) begin miscompares++; $display("FAIL ft_stored_usage: got %0d want 1", usage_f); end
    tick();
    push_f = 1'b0;
    #1;
    vectors++; if (dout_f !== 8'h4D) begin miscompares++; $display("FAIL ft_second: got %h want 4d", dout_f); end
    tick();
    pop_f = 1'b0;
    #1;
    vectors++; if (empty_f !== 1'b1) begin miscompares++; $display("FAIL ft_drained: got %b want 1", empty_f); end
  endtask

  task automatic test_wrap_depth3;
    logic [7:0] q [$];
    logic [7:0] val;
    int attempts = 0;
    int k = 0;
    while (attempts < 10 && k < 60) begin
      if (k % 3 != 2) begin
        val = 8'h20 + 8'(attempts);
        din_c = val; push_c = 1'b1; pop_c = 1'b0;
        #1;
        vectors++; if (full_c !== (q.size() == 3)) begin miscompares++; $display("FAIL d3_full_%0d: got %b want %b", k, full_c, q.size() == 3); end
        tick();
        if (q.size() < 3) q.push_back(val);
        attempts++;
      end else begin
        push_c = 1'b0; pop_c = 1'b1;
        #1;
        if (q.size() > 0) begin
          vectors++; if (dout_c !== q[0]) begin miscompares++; $display("FAIL d3_head_%0d: got %h want %h", k, dout_c, q[0]); end
        end
        tick();
        if (q.size() > 0) void'(q.pop_front());
      end
      vectors++; if (usage_c !== 2'(q.size())) begin miscompares++; $display("FAIL d3_usage_%0d: got %0d want %0d", k, usage_c, q.size()); end
      k++;
    end
    push_c = 1'b0; pop_c = 1'b1;
    for (int n = 0; n < 4 && q.size() > 0; n++) begin
      #1;
      vectors++; if (dout_c !== q[0]) begin miscompares++; $display("FAIL d3_drain_%0d: got %h want %h", n, dout_c, q[0]); end
      tick();
      void'(q.pop_front());
    end
    pop_c = 1'b0;
    #1;
    vectors++; if (empty_c !== 1'b1) begin miscompares++; $display("FAIL d3_empty: got %b want 1", empty_c); end
  endtask

  task automatic test_pass_through;
    din_p = 8'h5A; push_p = 1'b1; pop_p = 1'b0;
    #1;
    vectors++; if (dout_p !== 8'h5A) begin miscompares++; $display("FAIL pt_data: got %h want 5a", dout_p); end
    vectors++; if (empty_p !== 1'b0) begin miscompares++; $display("FAIL pt_empty_push: got %b want 0", empty_p); end
    vectors++; if (full_p !== 1'b1) begin miscompares++; $display("FAIL pt_full_nopop: got %b want 1", full_p); end
    vectors++; if (usage_p !== 1'b0) begin miscompares++; $display("FAIL pt_usage: got %0d want 0", usage_p); end
    din_p = 8'hC3; push_p = 1'b0; pop_p = 1'b1;
    #1;
    vectors++; if (dout_p !== 8'hC3) begin miscompares++; $display("FAIL pt_data2: got %h want c3", dout_p); end
    vectors++; if (empty_p !== 1'b1) begin miscompares++; $display("FAIL pt_empty_nopush: got %b want 1", empty_p); end
    vectors++; if (full_p !== 1'b0) begin miscompares++; $display("FAIL pt_full_pop: got %b want 0", full_p); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_no_fall_through();
    test_full_push_pop();
    test_back_to_back();
    test_flush_reset();
    test_fall_through();
    test_wrap_depth3();
    test_pass_through();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
